// File: rtl/decode_issue_ctrl.sv
// -----------------------------------------------------------------------------
// decode_issue_ctrl
//   Issue controller sitting between decode and execute. A scoreboard tracks
//   in-flight register writes; decoded instructions stall on RAW/WAW hazards,
//   control-flow ops hold issue until resolved, and serialising ops wait for
//   the pipeline to drain. One registered output slot feeds execute.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   t_*                 decode-side payload, register usage, class flags,
//                       valid/ready handshake (t_ready is combinational)
//   i_data/i_valid      registered payload to execute, i_ready from execute
//   wb_valid/wb_rd      writeback retiring a register write
//   br_valid/br_taken   control-flow resolution pulse
//   flush               one-cycle pulse after a taken resolution
//   busy_bits           scoreboard, bit n = write to xn pending
// -----------------------------------------------------------------------------
module decode_issue_ctrl #(
    parameter int DATA_W = 108,
    parameter int NREGS  = 32      // register index is 5 bits, so this stays 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] t_data,
    input  logic [4:0]        t_rs1,
    input  logic [4:0]        t_rs2,
    input  logic [4:0]        t_rd,
    input  logic              t_uses_rs1,
    input  logic              t_uses_rs2,
    input  logic              t_wr_rd,
    input  logic              t_is_ctrl,
    input  logic              t_is_serial,
    input  logic              t_valid,
    output logic              t_ready,
    output logic [DATA_W-1:0] i_data,
    output logic              i_valid,
    input  logic              i_ready,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    input  logic              br_valid,
    input  logic              br_taken,
    output logic              flush,
    output logic [NREGS-1:0]  busy_bits
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_BR = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NREGS-1:0]   r_sb;
    logic [NREGS-1:0]   w_sb_clr;
    logic [NREGS-1:0]   w_sb_byp;
    logic [NREGS-1:0]   w_sb_set;
    logic [NREGS-1:0]   w_sb_nxt;
    logic               r_valid;
    logic [DATA_W-1:0]  r_data;
    logic               r_flush;
    logic               w_flush_nxt;
    logic               w_slot_free;
    logic               w_hazard;
    logic               w_serial_block;
    logic               w_ready;
    logic               w_issue;

    // One-hot register mask; x0 is never tracked so its bit is forced low.
    function automatic logic [NREGS-1:0] f_onehot(input logic [4:0] idx);
        logic [NREGS-1:0] v;
        v      = {NREGS{1'b0}};
        v[idx] = 1'b1;
        v[0]   = 1'b0;
        return v;
    endfunction

    // Scoreboard bypass, hazard detection and issue decision.
    always_comb begin
        w_sb_clr = wb_valid ? f_onehot(wb_rd) : {NREGS{1'b0}};
        // Retiring writes are visible to this cycle's hazard check so a
        // dependent instruction issues in the same cycle its source retires.
        w_sb_byp = r_sb & ~w_sb_clr;
        w_hazard = (t_uses_rs1 && w_sb_byp[t_rs1]) ||
                   (t_uses_rs2 && w_sb_byp[t_rs2]) ||
                   (t_wr_rd    && w_sb_byp[t_rd]);
        w_slot_free    = !r_valid || i_ready;
        // Serialising ops need an empty slot and no pending writes at all.
        w_serial_block = t_is_serial && ((w_sb_byp != {NREGS{1'b0}}) || r_valid);
        w_ready  = (r_state == ST_RUN) && w_slot_free && !w_hazard &&
                   !w_serial_block && !rst;
        w_issue  = t_valid && w_ready;
        w_sb_set = (w_issue && t_wr_rd) ? f_onehot(t_rd) : {NREGS{1'b0}};
        // OR after the clear: a same-cycle set of the same register wins.
        w_sb_nxt = w_sb_byp | w_sb_set;
    end

    // Next-state and flush decision.
    always_comb begin
        w_state_nxt = r_state;
        w_flush_nxt = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_issue && t_is_ctrl) begin
                    w_state_nxt = ST_WAIT_BR;
                end else if (w_issue && t_is_serial) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_WAIT_BR: begin
                if (br_valid) begin
                    w_state_nxt = ST_RUN;
                    w_flush_nxt = br_taken;
                end else begin
                    w_state_nxt = ST_WAIT_BR;
                end
            end
            ST_DRAIN: begin
                if (!r_valid && (r_sb == {NREGS{1'b0}})) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Scoreboard and flush pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb    <= {NREGS{1'b0}};
            r_flush <= 1'b0;
        end else begin
            r_sb    <= w_sb_nxt;
            r_flush <= w_flush_nxt;
        end
    end

    // Output slot: load on issue, empty when execute takes it; data holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= {DATA_W{1'b0}};
        end else if (w_issue) begin
            r_valid <= 1'b1;
            r_data  <= t_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign t_ready   = w_ready;
    assign i_data    = r_data;
    assign i_valid   = r_valid;
    assign flush     = r_flush;
    assign busy_bits = r_sb;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
module tb_decode_issue_ctrl;

    localparam int DATA_W = 108;
    localparam int NREGS  = 32;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] t_data;
    logic [4:0]        t_rs1, t_rs2, t_rd;
    logic              t_uses_rs1, t_uses_rs2, t_wr_rd, t_is_ctrl, t_is_serial, t_valid;
    logic              t_ready;
    logic [DATA_W-1:0] i_data;
    logic              i_valid, i_ready;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic              br_valid, br_taken;
    logic              flush;
    logic [NREGS-1:0]  busy_bits;

    int checks = 0;
    int errors = 0;

    decode_issue_ctrl #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst),
        .t_data(t_data), .t_rs1(t_rs1), .t_rs2(t_rs2), .t_rd(t_rd),
        .t_uses_rs1(t_uses_rs1), .t_uses_rs2(t_uses_rs2), .t_wr_rd(t_wr_rd),
        .t_is_ctrl(t_is_ctrl), .t_is_serial(t_is_serial),
        .t_valid(t_valid), .t_ready(t_ready),
        .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .br_valid(br_valid), .br_taken(br_taken),
        .flush(flush), .busy_bits(busy_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        t_data = '0; t_rs1 = 5'd0; t_rs2 = 5'd0; t_rd = 5'd0;
        t_uses_rs1 = 1'b0; t_uses_rs2 = 1'b0; t_wr_rd = 1'b0;
        t_is_ctrl = 1'b0; t_is_serial = 1'b0; t_valid = 1'b0;
        wb_valid = 1'b0; wb_rd = 5'd0; br_valid = 1'b0; br_taken = 1'b0;
    endtask

    task automatic present(input logic [DATA_W-1:0] d, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                           input logic wr, input logic ctl, input logic ser);
        t_data = d; t_rs1 = rs1; t_uses_rs1 = u1; t_rs2 = rs2; t_uses_rs2 = u2;
        t_rd = rd; t_wr_rd = wr; t_is_ctrl = ctl; t_is_serial = ser; t_valid = 1'b1;
    endtask

    initial begin
        idle_inputs();
        i_ready = 1'b1;
        rst = 1'b1;
        t_valid = 1'b1;
        repeat (2) tick();
        // 1. Reset state
        chk("rst_i_valid", i_valid, 1'b0);
        chk("rst_busy", busy_bits, 32'h0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_t_ready", t_ready, 1'b0);
        t_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_t_ready", t_ready, 1'b1);

        // 2. RAW: LOAD x5 then ADD x6 <- x5
        present(108'hA1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        chk("load_ready", t_ready, 1'b1);
        tick();
        chk("load_ivalid", i_valid, 1'b1);
        chk("load_idata", i_data, 108'hA1);
        chk("load_busy", busy_bits, 32'h0000_0020);
        present(108'hA2, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        chk("raw_stall0", t_ready, 1'b0);
        tick();
        chk("raw_slot_empty", i_valid, 1'b0);
        chk("raw_stall1", t_ready, 1'b0);
        tick();
        chk("raw_stall2", t_ready, 1'b0);
        wb_valid = 1'b1; wb_rd = 5'd5;
        #1;
        chk("raw_bypass_ready", t_ready, 1'b1);
        tick();
        chk("add_idata", i_data, 108'hA2);
        chk("add_busy", busy_bits, 32'h0000_0040);

        // 3. Same-cycle set/clear on x7
        present(108'hB1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        wb_valid = 1'b1; wb_rd = 5'd6;
        tick();
        chk("b1_busy", busy_bits, 32'h0000_0080);
        present(108'hB2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        wb_valid = 1'b1; wb_rd = 5'd7;
        #1;
        chk("waw_bypass_ready", t_ready, 1'b1);
        tick();
        chk("setclr_idata", i_data, 108'hB2);
        chk("setclr_busy", busy_bits, 32'h0000_0080);
        t_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd7;
        tick();
        chk("x7_cleared", busy_bits, 32'h0);
        wb_valid = 1'b1; wb_rd = 5'd0;
        tick();
        chk("wb_x0_ignored", busy_bits, 32'h0);
        wb_valid = 1'b0;

        // 4. Taken branch
        present(108'hC1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("beq_ready", t_ready, 1'b1);
        tick();
        chk("beq_idata", i_data, 108'hC1);
        present(108'hD1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wait_br_stall", t_ready, 1'b0);
            chk("wait_br_noflush", flush, 1'b0);
            tick();
        end
        br_valid = 1'b1; br_taken = 1'b1;
        #1;
        chk("resolve_cycle_stall", t_ready, 1'b0);
        tick();
        br_valid = 1'b0; br_taken = 1'b0; t_valid = 1'b0;
        #1;
        chk("taken_flush", flush, 1'b1);
        chk("taken_back_run", t_ready, 1'b1);
        chk("wrong_path_not_issued", i_valid, 1'b0);
        tick();
        chk("flush_one_cycle", flush, 1'b0);

        // 4b. Not-taken branch
        present(108'hC2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        t_valid = 1'b0;
        br_valid = 1'b1; br_taken = 1'b0;
        tick();
        br_valid = 1'b0;
        #1;
        chk("nt_flush", flush, 1'b0);
        chk("nt_back_run", t_ready, 1'b1);
        tick();
        chk("nt_flush_later", flush, 1'b0);

        // 5. Serial: FENCE behind pending x3
        present(108'hE1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        chk("e1_busy", busy_bits, 32'h0000_0008);
        present(108'hF1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("fence_stall_slot", t_ready, 1'b0);
        tick();
        chk("fence_stall_sb0", t_ready, 1'b0);
        tick();
        chk("fence_stall_sb1", t_ready, 1'b0);
        wb_valid = 1'b1; wb_rd = 5'd3;
        #1;
        chk("fence_ready_on_wb", t_ready, 1'b1);
        tick();
        wb_valid = 1'b0;
        chk("fence_idata", i_data, 108'hF1);
        chk("fence_ivalid", i_valid, 1'b1);
        present(108'hE2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        i_ready = 1'b0;
        #1;
        chk("drain_stall0", t_ready, 1'b0);
        tick();
        chk("drain_hold_ivalid", i_valid, 1'b1);
        i_ready = 1'b1;
        #1;
        chk("drain_stall1", t_ready, 1'b0);
        tick();
        chk("drain_slot_empty", i_valid, 1'b0);
        chk("drain_stall2", t_ready, 1'b0);
        tick();
        chk("drain_exit_ready", t_ready, 1'b1);
        tick();
        chk("e2_idata", i_data, 108'hE2);
        chk("e2_busy", busy_bits, 32'h0000_0200);

        // 6. Backpressure, then async reset mid-stall
        i_ready = 1'b0;
        present(108'hF2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_t_ready", t_ready, 1'b0);
            chk("bp_ivalid", i_valid, 1'b1);
            chk("bp_idata", i_data, 108'hE2);
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ivalid", i_valid, 1'b0);
        chk("async_rst_busy", busy_bits, 32'h0);
        chk("async_rst_t_ready", t_ready, 1'b0);
        tick();
        rst = 1'b0;
        t_valid = 1'b0;
        i_ready = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd9;
        tick();
        wb_valid = 1'b0;
        chk("stale_wb_ignored", busy_bits, 32'h0);
        chk("after_rst_ready", t_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
